// File: rtl/demux8_pkg.sv
// Shared constants and FSM state type for the demux8_collector slice.
package demux8_pkg;

    localparam int SLOTS = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } demux8_state_t;

endpackage

// File: rtl/decoder3to8.sv
// 3-bit slot index to one-hot write enable; all zeros when en is low.
module decoder3to8
    import demux8_pkg::*;
(
    input  logic [IDX_W-1:0] sel,
    input  logic             en,
    output logic [SLOTS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/demux8_collector.sv
// Steers a word stream into 8 slot registers and hands them out as one frame.
// Define DEMUX8_ADDR_EN to target slots by in_addr instead of an internal counter.
module demux8_collector
    import demux8_pkg::*;
#(
    parameter int N = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
`ifdef DEMUX8_ADDR_EN
    input  logic [IDX_W-1:0] in_addr,
`endif
    input  logic             clear,
    output logic [N-1:0]     out00,
    output logic [N-1:0]     out01,
    output logic [N-1:0]     out02,
    output logic [N-1:0]     out03,
    output logic [N-1:0]     out04,
    output logic [N-1:0]     out05,
    output logic [N-1:0]     out06,
    output logic [N-1:0]     out07,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             dbg_state,
    output logic [IDX_W-1:0] dbg_idx
);

    // Handshake: a word moves when in_valid & in_ready at posedge clk; a
    // frame moves when out_valid & out_ready. Both readies/valids are pure
    // functions of state, so neither side ever waits on the other's valid.

    demux8_state_t    state, next_state;
    logic [IDX_W-1:0] idx;
    logic [SLOTS-1:0] written;
    logic [SLOTS-1:0] wr_en;
    logic [IDX_W-1:0] target;
    logic [N-1:0]     slot [SLOTS];
    logic             accept;
    logic             take;

    assign in_ready  = (state == FILL);
    assign out_valid = (state == FULL);
    assign take      = out_valid & out_ready;
    // clear drops a coincident word so the new frame starts cleanly at slot 0
    assign accept    = in_valid & in_ready & ~clear;

`ifdef DEMUX8_ADDR_EN
    assign target = in_addr;
`else
    assign target = idx;
`endif

    decoder3to8 u_dec (
        .sel    (target),
        .en     (accept),
        .onehot (wr_en)
    );

    always_comb begin
        next_state = state;
        case (state)
            FILL: if (accept && ((written | wr_en) == '1)) next_state = FULL;
            FULL: if (take) next_state = FILL;
            default: next_state = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FILL;
            idx     <= '0;
            written <= '0;
        end else begin
            state <= next_state;
            if (state == FILL) begin
                if (clear) begin
                    idx     <= '0;
                    written <= '0;
                end else if (accept) begin
                    idx     <= idx + 1'b1;
                    written <= written | wr_en;
                end
            end else if (take) begin
                idx     <= '0;
                written <= '0;
            end
        end
    end

    // Slots keep their contents across a take; only reset zeroes them.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SLOTS; i++) begin
            if (rst) begin
                slot[i] <= '0;
            end else if (wr_en[i]) begin
                slot[i] <= in_data;
            end
        end
    end

    assign out00     = slot[0];
    assign out01     = slot[1];
    assign out02     = slot[2];
    assign out03     = slot[3];
    assign out04     = slot[4];
    assign out05     = slot[5];
    assign out06     = slot[6];
    assign out07     = slot[7];
    assign dbg_state = state;
    assign dbg_idx   = idx;

endmodule
